// File: rtl/ifid_hazard_ctrl.sv
// Fetch/decode hazard controller: load-use stalls, taken-branch flushes and mult/div decode holds.
// Define HAZARD_STALL_COUNT_EN to add the saturating StallCount output.
module ifid_hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 4
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic [31:0] IFID_Instr,
    input  logic        IDEX_MemRead,
    input  logic [4:0]  IDEX_Rt,
    input  logic        BranchTaken,
    input  logic        MulDivStart,
    input  logic        ExtStall,
    output logic        PCWrite,
    output logic        IFIDWrite,
    output logic        IFIDFlush,
    output logic        IDEXBubble,
`ifdef HAZARD_STALL_COUNT_EN
    output logic [31:0] StallCount,
`endif
    output logic        State
);

    typedef enum logic {RUN = 1'b0, MULDIV = 1'b1} state_t;

    state_t             state_reg;
    logic [CNT_W-1:0]   cnt_reg;

    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rt;
    logic       load_use;

    assign opcode = IFID_Instr[31:26];
    assign rs     = IFID_Instr[25:21];
    assign rt     = IFID_Instr[20:16];

    // R-type, beq/bne and byte/half/word stores read rt as a source operand
    assign uses_rt  = (opcode == 6'h00) || (opcode == 6'h04) || (opcode == 6'h05) ||
                      (opcode == 6'h28) || (opcode == 6'h29) || (opcode == 6'h2B);
    assign load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                      ((IDEX_Rt == rs) || (uses_rt && (IDEX_Rt == rt)));

    always_comb begin
        PCWrite    = 1'b1;
        IFIDWrite  = 1'b1;
        IFIDFlush  = 1'b0;
        IDEXBubble = 1'b0;
        if (Rst) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IFIDFlush  = 1'b1;
            IDEXBubble = 1'b1;
        end else if (state_reg == MULDIV) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end else if (ExtStall) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
        end else if (load_use) begin
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
            IDEXBubble = 1'b1;
        end else if (MulDivStart) begin
            // the mult/div itself goes down the pipe, only fetch is frozen
            PCWrite    = 1'b0;
            IFIDWrite  = 1'b0;
        end else if (BranchTaken) begin
            IFIDFlush  = 1'b1;
        end
    end

    assign State = state_reg;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            case (state_reg)
                RUN: begin
                    if (!ExtStall && !load_use && MulDivStart) begin
                        state_reg <= MULDIV;
                        cnt_reg   <= CNT_W'(MULDIV_LAT - 2);
                    end
                end
                MULDIV: begin
                    if (!ExtStall) begin
                        if (cnt_reg == '0) begin
                            state_reg <= RUN;
                        end else begin
                            cnt_reg <= cnt_reg - 1'b1;
                        end
                    end
                end
                default: begin
                    state_reg <= RUN;
                    cnt_reg   <= '0;
                end
            endcase
        end
    end

`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] stall_count_reg;

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            stall_count_reg <= '0;
        end else if (!PCWrite && (stall_count_reg != 32'hFFFF_FFFF)) begin
            stall_count_reg <= stall_count_reg + 32'd1;
        end
    end

    assign StallCount = stall_count_reg;
`endif

endmodule

// File: tb/tb_ifid_hazard_ctrl.sv
// Self-checking bench for ifid_hazard_ctrl: vector table, hand sequences and a randomized model run.
module tb_ifid_hazard_ctrl;

    localparam int MULDIV_LAT = 4;

    logic        Clk;
    logic        Rst;
    logic [31:0] IFID_Instr;
    logic        IDEX_MemRead;
    logic [4:0]  IDEX_Rt;
    logic        BranchTaken;
    logic        MulDivStart;
    logic        ExtStall;
    logic        PCWrite;
    logic        IFIDWrite;
    logic        IFIDFlush;
    logic        IDEXBubble;
    logic        State;
`ifdef HAZARD_STALL_COUNT_EN
    logic [31:0] StallCount;
`endif

    ifid_hazard_ctrl #(.MULDIV_LAT(MULDIV_LAT), .CNT_W(4)) dut (
        .Clk(Clk), .Rst(Rst), .IFID_Instr(IFID_Instr), .IDEX_MemRead(IDEX_MemRead),
        .IDEX_Rt(IDEX_Rt), .BranchTaken(BranchTaken), .MulDivStart(MulDivStart),
        .ExtStall(ExtStall), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IFIDFlush(IFIDFlush), .IDEXBubble(IDEXBubble),
`ifdef HAZARD_STALL_COUNT_EN
        .StallCount(StallCount),
`endif
        .State(State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int check_count = 0;
    int pass_count  = 0;

    // compare {PCWrite,IFIDWrite,IFIDFlush,IDEXBubble,State}; IFIDWrite ignored when a flush is expected
    task automatic check_out(input string name, input logic [4:0] exp);
        logic [4:0] act;
        logic [4:0] mask;
        act  = {PCWrite, IFIDWrite, IFIDFlush, IDEXBubble, State};
        mask = exp[2] ? 5'b10111 : 5'b11111;
        check_count++;
        if ((act & mask) === (exp & mask)) begin
            pass_count++;
            $display("ok   %s: pc/ifw/flush/bub/state=%b", name, act);
        end else begin
            $display("FAIL %s: got pc/ifw/flush/bub/state=%b, required %b", name, act, exp);
        end
    endtask

    task automatic check_val(input string name, input int act, input int exp);
        check_count++;
        if (act == exp) begin
            pass_count++;
            $display("ok   %s: %0d", name, act);
        end else begin
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] instr, input logic mr, input logic [4:0] rtv,
                          input logic br, input logic mds, input logic ext);
        IFID_Instr   = instr;
        IDEX_MemRead = mr;
        IDEX_Rt      = rtv;
        BranchTaken  = br;
        MulDivStart  = mds;
        ExtStall     = ext;
    endtask

    // next posedge, then settle a little
    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        Rst = 1'b0;
        #1;
    endtask

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        mr;
        logic [4:0]  rtv;
        logic        br;
        logic        mds;
        logic        ext;
        logic [4:0]  exp;
    } vec_t;

    vec_t vecs[12];

    // Reference model: remaining decode-hold cycles after the issue cycle
    int model_hold;

    function automatic logic [4:0] model_out(input logic rst, input logic [31:0] instr,
                                             input logic mr, input logic [4:0] rtv,
                                             input logic br, input logic mds, input logic ext);
        logic [5:0] op;
        logic       lu;
        logic       st;
        op = instr[31:26];
        lu = mr && (rtv != 0) && (rtv == instr[25:21] ||
             ((op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h29, 6'h2B}) && rtv == instr[20:16]));
        st = (model_hold > 0);
        if (rst)       return 5'b00110;
        if (st)        return 5'b00011;
        if (ext)       return 5'b00000;
        if (lu)        return 5'b00010;
        if (mds)       return 5'b00000;
        if (br)        return 5'b11100;
        return 5'b11000;
    endfunction

    function automatic void model_step(input logic rst, input logic [4:0] outs,
                                       input logic mds, input logic ext);
        if (rst) begin
            model_hold = 0;
        end else if (model_hold > 0) begin
            if (!ext) model_hold = model_hold - 1;
        end else if (mds && outs == 5'b00000 && !ext) begin
            model_hold = MULDIV_LAT - 1;
        end
    endfunction

    initial begin
        int stalls;
        int states;
        logic [4:0] exp;

        vecs[0]  = '{"loaduse_rs",     32'h0109_5020, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 5'b00010};
        vecs[1]  = '{"no_memread",     32'h0109_5020, 1'b0, 5'd8, 1'b0, 1'b0, 1'b0, 5'b11000};
        vecs[2]  = '{"rt_zero",        32'h0109_5020, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 5'b11000};
        vecs[3]  = '{"lw_rt_unused",   32'h8D09_0004, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'b11000};
        vecs[4]  = '{"sw_rt_used",     32'hAD09_0004, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'b00010};
        vecs[5]  = '{"branch",         32'h0000_0000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 5'b11100};
        vecs[6]  = '{"branch_loaduse", 32'h0109_5020, 1'b1, 5'd8, 1'b1, 1'b0, 1'b0, 5'b00010};
        vecs[7]  = '{"ext_over_all",   32'h0109_5020, 1'b1, 5'd8, 1'b1, 1'b0, 1'b1, 5'b00000};
        vecs[8]  = '{"loaduse_mds",    32'h0109_5020, 1'b1, 5'd8, 1'b0, 1'b1, 1'b0, 5'b00010};
        vecs[9]  = '{"ext_mds",        32'h0000_0000, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1, 5'b00000};
        vecs[10] = '{"beq_rt_used",    32'h1009_0000, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0, 5'b00010};
        vecs[11] = '{"lw_rs_used",     32'h8D09_0004, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0, 5'b00010};

        Rst = 1'b1;
        set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #2;
        check_out("reset_hold", 5'b00110);
        tick();
        check_out("reset_hold2", 5'b00110);
        tick();
        Rst = 1'b0;
        #1;
        check_out("after_release", 5'b11000);

        // single-cycle vectors, all from RUN; none of them may leave RUN
        foreach (vecs[i]) begin
            set_in(vecs[i].instr, vecs[i].mr, vecs[i].rtv, vecs[i].br, vecs[i].mds, vecs[i].ext);
            #1;
            check_out(vecs[i].name, vecs[i].exp);
            tick();
        end
        set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        #1;
        check_out("idle_after_table", 5'b11000);

        // mult/div: 4 hold cycles, 3 of them in MULDIV
        stalls = 0;
        states = 0;
        set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 10; c++) begin
            #1;
            if (!PCWrite) stalls++;
            if (State) states++;
            tick();
            MulDivStart = 1'b0;
        end
        check_val("muldiv_hold_cycles", stalls, 4);
        check_val("muldiv_state_cycles", states, 3);

        // mult/div with a 2-cycle external stall in the middle
        stalls = 0;
        set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        for (int c = 0; c < 12; c++) begin
            ExtStall = (c == 2 || c == 3);
            #1;
            if (!PCWrite) stalls++;
            tick();
            MulDivStart = 1'b0;
        end
        ExtStall = 1'b0;
        check_val("muldiv_ext_hold_cycles", stalls, 6);

        // reset pulse mid-MULDIV
        set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        MulDivStart = 1'b0;
        #1;
        check_out("muldiv_entered", 5'b00011);
        Rst = 1'b1;
        #1;
        check_out("rst_mid_muldiv", 5'b00110);
        tick();
        Rst = 1'b0;
        #1;
        check_out("after_mid_reset", 5'b11000);
        tick();
        check_out("no_residual_stall", 5'b11000);

`ifdef HAZARD_STALL_COUNT_EN
        do_reset();
        check_val("stallcount_reset", int'(StallCount), 0);
        set_in(32'h0109_5020, 1'b1, 5'd8, 1'b0, 1'b0, 1'b0);
        tick();
        set_in(32'h0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
        tick();
        MulDivStart = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        check_val("stallcount_lu_muldiv", int'(StallCount), 5);
        dut.stall_count_reg = 32'hFFFF_FFFD;
        ExtStall = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        ExtStall = 1'b0;
        check_val("stallcount_saturate", int'(StallCount), -1);
`endif

        // randomized run against the reference model
        do_reset();
        model_hold = 0;
        for (int c = 0; c < 400; c++) begin
            logic [31:0] instr;
            logic [4:0]  rtv;
            Rst = ($urandom_range(0, 40) == 0);
            instr = {$urandom_range(0, 3) == 0 ? 6'h2B : 6'($urandom_range(0, 5)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 16'($urandom)};
            rtv = 5'($urandom_range(0, 3));
            set_in(instr, 1'($urandom_range(0, 1)), rtv, 1'($urandom_range(0, 2) == 0),
                   1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 4) == 0));
            #1;
            exp = model_out(Rst, IFID_Instr, IDEX_MemRead, IDEX_Rt, BranchTaken, MulDivStart, ExtStall);
            exp[0] = (model_hold > 0) && !Rst;
            check_out($sformatf("random_%0d", c), exp);
            model_step(Rst, exp, MulDivStart, ExtStall);
            tick();
        end
        Rst = 1'b0;

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/ifid_hazard_ctrl.md
Name: ifid_hazard_ctrl

Overview:
Hazard and stall controller for the fetch/decode pipeline register. It drives the write enable and flush of that register, the PC write enable, and bubble insertion into decode/execute. It detects load-use hazards on the instruction held in fetch/decode, flushes on taken branches resolved in decode, and holds decode for multi-cycle mult/div operations through a small FSM with a latency counter.

Parameters:
MULDIV_LAT, 4, cycles decode is held for a mult/div issue; legal range 2..15.
CNT_W, 4, width of the mult/div latency counter.

Ports:
Clk  input  1  rising-edge clock
Rst  input  1  reset; asynchronous, active-high
IFID_Instr  input  32  instruction in fetch/decode; opcode [31:26], rs [25:21], rt [20:16]
IDEX_MemRead  input  1  instruction in decode/execute is a load
IDEX_Rt  input  5  destination rt of that load
BranchTaken  input  1  branch in decode resolved taken
MulDivStart  input  1  decode is issuing a mult/div
ExtStall  input  1  external freeze, e.g. memory wait
PCWrite  output  1  PC update enable
IFIDWrite  output  1  fetch/decode register load enable
IFIDFlush  output  1  synchronous clear to fetch/decode register
IDEXBubble  output  1  zero control fields entering decode/execute
State  output  1  0=RUN, 1=MULDIV

Behaviour:
- Clock and reset: one clock, Clk. Rst is asynchronous and active-high.
- Reset state: State=RUN, counter=0.
- While Rst=1, outputs are forced: PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1.
- After release with no hazard inputs: PCWrite=1, IFIDWrite=1, IFIDFlush=0, IDEXBubble=0.
- Outputs are combinational from the registered state and the current inputs. Decisions take effect in the same cycle.
- usesRt: opcode is one of 0x00, 0x04, 0x05, 0x28, 0x29, 0x2B.
- LoadUse: IDEX_MemRead && IDEX_Rt!=0 && (IDEX_Rt==rs || (usesRt && IDEX_Rt==rt)).
- Priority in RUN, highest first:
  - ExtStall=1: PCWrite=0, IFIDWrite=0, IFIDFlush=0, IDEXBubble=0. State is held.
  - LoadUse: PCWrite=0, IFIDWrite=0, IDEXBubble=1, IFIDFlush=0. BranchTaken and MulDivStart are ignored this cycle because operands are not valid. This lasts exactly 1 cycle per hazard, since the load advances.
  - MulDivStart: PCWrite=0, IFIDWrite=0, IDEXBubble=0 (the mult/div itself proceeds). Next state is MULDIV, counter <= MULDIV_LAT-2. BranchTaken is ignored.
  - BranchTaken: IFIDFlush=1, PCWrite=1, IDEXBubble=0, IFIDWrite don't-care. Flush dominates at the register. Exactly one cycle.
  - Otherwise: normal flow.
- MULDIV state:
  - PCWrite=0, IFIDWrite=0, IDEXBubble=1.
  - BranchTaken, MulDivStart and LoadUse are ignored.
  - If ExtStall=0: when counter==0, next state is RUN; else counter decrements.
  - If ExtStall=1: counter and state hold.
- Total decode hold for one mult/div with no ExtStall is MULDIV_LAT cycles: the issue cycle plus MULDIV_LAT-1 cycles in MULDIV.
- Rst asserted mid-MULDIV: immediate return to RUN, counter=0, no residual stall after release.
- Counter never wraps: it only decrements from a nonzero value.

Optional Feature:
Macro HAZARD_STALL_COUNT_EN.
- Defined: adds output StallCount (32 bits).
  - Increments once per cycle in which PCWrite=0 and Rst=0, covering all stall sources.
  - Saturates at 0xFFFFFFFF.
  - Cleared asynchronously by Rst.
- Undefined: the port and register are absent; all other behaviour is identical.

Test Plan:
- Reset: Rst=1 for 2 cycles, all other inputs 0 -> PCWrite=0, IFIDWrite=0, IFIDFlush=1, IDEXBubble=1, State=0. After release -> 1/1/0/0.
- Load-use: IDEX_MemRead=1, IDEX_Rt=8, IFID_Instr=0x01095020 (add $10,$8,$9) -> exactly 1 cycle with PCWrite=0, IFIDWrite=0, IDEXBubble=1. Then with IDEX_MemRead=0 -> normal flow. Repeat with IDEX_Rt=0 -> no stall.
- Rt not used: IDEX_Rt=9, IFID_Instr=0x8D090004 (lw $9,4($8), opcode 0x23) -> no stall. Same with opcode 0x2B -> stall.
- Branch: BranchTaken=1 for 1 cycle -> IFIDFlush=1, PCWrite=1. BranchTaken=1 together with a LoadUse hazard -> IFIDFlush=0, stall only.
- Mult/div: MULDIV_LAT=4, MulDivStart=1 for 1 cycle -> PCWrite=0 for exactly 4 cycles, State=1 for 3 cycles. With ExtStall=1 for 2 cycles mid-MULDIV -> 6 hold cycles. Rst pulse mid-MULDIV -> State=0 immediately.
- With HAZARD_STALL_COUNT_EN: run the load-use case plus the 4-cycle mult/div -> StallCount=5. Preload a near-max value via forced stalls -> holds at 0xFFFFFFFF.
